// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a tx_en / tx_done handshake.
// Optional per-byte watchdog is compiled in when UART_TXQ_TIMEOUT_EN is defined.
module uart_tx_fifo #(
  parameter int          DATA_WIDTH  = 8,
  parameter int          DEPTH_LOG2  = 4,
  parameter int unsigned TIMEOUT_CYC = 65536
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  flush,
  input  logic                  tx_done,
  output logic                  tx_en,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  busy,
  output logic                  timeout
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef logic [PW-1:0] ptr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_GAP
  } state_e;

  state_e                state_q, state_d;
  ptr_t                  wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_en_q, tx_en_d;
  logic                  empty, full, push, pop, wd_hit;

  // Extra pointer MSB separates "wrapped once" (full) from "caught up" (empty).
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);

  // flush wins over a simultaneous write, which is dropped.
  assign push    = s_valid && !full && !flush;
  assign s_ready = !full;
  assign level   = wr_ptr_q - rd_ptr_q;
  assign busy    = (state_q != ST_IDLE);
  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_q;

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-2:0]] <= s_data;
  end

  // NOTE: every comb output gets its default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty && !flush) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rd_ptr_q[PW-2:0]];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE:   state_d = ST_WAIT_LO;
      // A tx_done still high from the previous frame is not a completion.
      ST_WAIT_LO: if (!tx_done) state_d = ST_WAIT_HI;
      ST_WAIT_HI: if (tx_done)  state_d = ST_GAP;
      ST_GAP:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (wd_hit) state_d = ST_IDLE;
    tx_en_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
    end
  end

`ifdef UART_TXQ_TIMEOUT_EN
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;
  logic        waiting;

  assign waiting = (state_q == ST_WAIT_LO) || (state_q == ST_WAIT_HI);
  assign wd_hit  = waiting && (wd_cnt_q == 32'(TIMEOUT_CYC - 1));

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_d == ST_ISSUE) wd_cnt_d = '0;
    else if (waiting)        wd_cnt_d = wd_cnt_q + 32'd1;
    timeout_d = (timeout_q && !flush) || wd_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: a queue-based reference model plus a
// behavioural transmitter that answers tx_en with a tx_done low/high frame.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       flush;
  logic       tx_done;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [4:0] level;
  logic       busy;
  logic       timeout;

  uart_tx_fifo dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .flush   (flush),
    .tx_done (tx_done),
    .tx_en   (tx_en),
    .tx_data (tx_data),
    .level   (level),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: queued bytes, the byte last handed out, and frame bookkeeping.
  byte unsigned mq[$];
  byte unsigned sent[$];
  logic [7:0]   m_data;
  bit           m_inflight;
  bit           m_low_seen;
  int           m_issue_edge;
  int           m_idle_at;
  int           n = 0;

  // Behavioural transmitter.
  int ack_delay = 0;
  int frame_len = 3;
  int acnt, tcnt;
  bit pend, stall;

  task automatic model_reset();
    mq.delete();
    m_data     = 8'h00;
    m_inflight = 1'b0;
    m_low_seen = 1'b0;
    m_idle_at  = 0;
    pend       = 1'b0;
    tcnt       = 0;
    acnt       = 0;
    tx_done    = 1'b1;
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit fl);
    bit dd, pop_e, push_e;
    s_valid = v;
    s_data  = d;
    flush   = fl;
    dd      = tx_done;
    @(posedge clk);
    n++;
    pop_e  = !m_inflight && (n >= m_idle_at) && (mq.size() > 0) && !fl;
    push_e = v && (mq.size() < 16) && !fl;
    // A frame completes once tx_done has been seen low after the start and then high again.
    if (m_inflight) begin
      if (!m_low_seen) begin
        if (n >= m_issue_edge + 2 && dd == 1'b0) m_low_seen = 1'b1;
      end else if (dd == 1'b1) begin
        m_inflight = 1'b0;
        m_idle_at  = n + 2;
      end
    end
    if (pop_e) begin
      m_data       = mq.pop_front();
      m_inflight   = 1'b1;
      m_low_seen   = 1'b0;
      m_issue_edge = n;
    end
    if (push_e) mq.push_back(d);
    if (fl) mq.delete();
    #1;
    check("tx_en",   tx_en,   pop_e);
    check("tx_data", tx_data, m_data);
    check("level",   level,   mq.size());
    check("s_ready", s_ready, mq.size() < 16);
    check("busy",    busy,    m_inflight || (n + 1 < m_idle_at));
    check("timeout", timeout, 0);
    if (tx_en) sent.push_back(tx_data);
    if (tx_en) begin
      pend = 1'b1;
      acnt = ack_delay;
      tcnt = frame_len;
    end
    if (pend) begin
      if (acnt == 0) begin
        tx_done = 1'b0;
        pend    = 1'b0;
      end else acnt--;
    end else if (!tx_done && !stall && tcnt > 0) begin
      tcnt--;
      if (tcnt == 0) tx_done = 1'b1;
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((mq.size() != 0 || m_inflight || (n + 1 < m_idle_at)) && k < budget) begin
      step(1'b0, 8'h00, 1'b0);
      k++;
    end
    check("drain_bound", k < budget, 1);
    check("drain_busy",  busy,       0);
    check("drain_level", level,      0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int w, k;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    flush   = 1'b0;
    stall   = 1'b0;
    model_reset();
    #1;
    check("rst_level", level, 0);
    check("rst_ready", s_ready, 1);
    check("rst_tx_en", tx_en, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_timeout", timeout, 0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;

    repeat (10) step(1'b0, 8'h00, 1'b0);

    // Single byte into an empty FIFO: tx_en is sampled by the transmitter two edges later.
    sent.delete();
    step(1'b1, 8'hA5, 1'b0);
    w = n;
    k = 0;
    while (!tx_en && k < 10) begin
      step(1'b0, 8'h00, 1'b0);
      k++;
    end
    check("a5_seen", tx_en, 1);
    check("a5_latency", n + 1 - w, 2);
    drain(100);
    check("a5_count", sent.size(), 1);
    check("a5_data", sent[0], 8'hA5);

    // Late acknowledge: tx_done stays high for a while after tx_en.
    sent.delete();
    ack_delay = 3;
    for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
    drain(200);
    check("late_ack_count", sent.size(), 3);
    ack_delay = 0;

    // Stalled transmitter: 17 bytes fit (one in flight), the 18th is refused.
    sent.delete();
    stall = 1'b1;
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0);
    repeat (4) step(1'b1, 8'h11, 1'b0);
    check("full_level", level, 16);
    check("full_ready", s_ready, 0);
    step(1'b0, 8'h00, 1'b0);
    stall = 1'b0;
    drain(800);
    check("full_count", sent.size(), 17);
    for (int i = 0; i < 17 && i < sent.size(); i++) check("full_order", sent[i], i);

    // flush with five queued: the in-flight byte still completes, nothing else is sent.
    sent.delete();
    stall = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
    check("flush_pre_level", level, 5);
    step(1'b1, 8'h99, 1'b1);
    check("flush_level", level, 0);
    stall = 1'b0;
    drain(200);
    repeat (30) step(1'b0, 8'h00, 1'b0);
    check("flush_count", sent.size(), 1);
    check("flush_byte", sent[0], 8'h40);

    // Randomised traffic with varying frame lengths and acknowledge delays.
    for (int c = 0; c < 3000; c++) begin
      if (c % 97 == 0) begin
        frame_len = $urandom_range(2, 8);
        ack_delay = $urandom_range(0, 2);
      end
      step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 199) == 0);
    end
    ack_delay = 0;
    drain(3000);

    // tx_done stuck low: without the watchdog the FSM simply keeps waiting.
    stall = 1'b1;
    step(1'b1, 8'h77, 1'b0);
    repeat (300) step(1'b0, 8'h00, 1'b0);
    check("stuck_busy", busy, 1);
    stall = 1'b0;
    drain(100);

    // Reset in the middle of a frame: tx_en drops at once, queued bytes are lost.
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'h5B, 1'b0);
    k = 0;
    while (!tx_en && k < 10) begin
      step(1'b0, 8'h00, 1'b0);
      k++;
    end
    check("mid_rst_pre_tx_en", tx_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_en", tx_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_tx_data", tx_data, 0);
    model_reset();
    #3;
    rst_n = 1'b1;
    repeat (10) step(1'b0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
